stopwatch_ctrl: RTL and testbench

- Control unit for the stopwatch. Takes the run/stop, clear and lap buttons after they have passed through the per-button debouncers.
- Sequences the stopwatch counter datapath with run, clear and lap-freeze commands.
- Sits between the debouncer outputs and the tick-counter/display datapath, as a Moore FSM with registered outputs.

---
 rtl/stopwatch_ctrl_if.sv | 20 ++
 rtl/stopwatch_ctrl.sv | 101 ++++++++++
 tb/tb_stopwatch_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_ctrl_if.sv
// Button and command bundle between the debouncers, the stopwatch controller and the datapath.
interface stopwatch_ctrl_if;
  logic       i_btn_run;
  logic       i_btn_clear;
  logic       i_btn_lap;
  logic       o_run;
  logic       o_clear;
  logic       o_lap;
  logic [1:0] o_state;

  modport master (
    output i_btn_run, i_btn_clear, i_btn_lap,
    input  o_run, o_clear, o_lap, o_state
  );

  modport slave (
    input  i_btn_run, i_btn_clear, i_btn_lap,
    output o_run, o_clear, o_lap, o_state
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: turns debounced button edges into run, clear and lap-freeze commands.
//
// state  | meaning
// STOP   | counter halted, display live
// RUN    | counter enabled
// CLEAR  | counter clear pulse held for CLEAR_CYCLES cycles
// LAP    | counter enabled, display frozen
module stopwatch_ctrl #(
  parameter int CLEAR_CYCLES = 4
) (
  input logic             clk,
  input logic             rst,
  stopwatch_ctrl_if.slave bus
);

  localparam int CW = $clog2(CLEAR_CYCLES + 1);
  localparam logic [CW-1:0] CLR_LAST = CW'(CLEAR_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_STOP  = 2'b00,
    ST_RUN   = 2'b01,
    ST_CLEAR = 2'b10,
    ST_LAP   = 2'b11
  } state_t;

  // bit order {lap, clear, run}
  logic [2:0] btn_q;
  logic [2:0] btn_qq;
  logic [2:0] evt;

  state_t        state, state_nxt;
  logic [CW-1:0] clr_cnt, clr_cnt_nxt;
  logic          run_nxt, clear_nxt, lap_nxt;
  logic          run_r, clear_r, lap_r;

  // Event is registered so a button edge reaches the state register two clocks after sampling.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_q  <= '0;
      btn_qq <= '0;
      evt    <= '0;
    end else begin
      btn_q  <= {bus.i_btn_lap, bus.i_btn_clear, bus.i_btn_run};
      btn_qq <= btn_q;
      evt    <= btn_q & ~btn_qq;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_STOP;
      clr_cnt <= '0;
      run_r   <= 1'b0;
      clear_r <= 1'b0;
      lap_r   <= 1'b0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
      run_r   <= run_nxt;
      clear_r <= clear_nxt;
      lap_r   <= lap_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = '0;
    case (state)
      ST_STOP: begin
        if (evt[0])      state_nxt = ST_RUN;
        else if (evt[1]) state_nxt = ST_CLEAR;
      end
      ST_RUN: begin
        if (evt[0])      state_nxt = ST_STOP;
        else if (evt[2]) state_nxt = ST_LAP;
      end
      ST_LAP: begin
        if (evt[0])      state_nxt = ST_STOP;
        else if (evt[2]) state_nxt = ST_RUN;
      end
      ST_CLEAR: begin
        if (clr_cnt == CLR_LAST) state_nxt = ST_STOP;
        else                     clr_cnt_nxt = clr_cnt + CW'(1);
      end
      default: state_nxt = ST_STOP;
    endcase
  end

  // Outputs decoded from the next state and registered alongside it, so they track state glitch-free.
  always_comb begin
    run_nxt   = (state_nxt == ST_RUN) || (state_nxt == ST_LAP);
    clear_nxt = (state_nxt == ST_CLEAR);
    lap_nxt   = (state_nxt == ST_LAP);
  end

  assign bus.o_run   = run_r;
  assign bus.o_clear = clear_r;
  assign bus.o_lap   = lap_r;
  assign bus.o_state = state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed test-plan steps plus random button traffic against a history-based model.
module tb_stopwatch_ctrl;
  localparam int CC = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  stopwatch_ctrl_if sw_if ();

  stopwatch_ctrl #(.CLEAR_CYCLES(CC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sw_if.slave)
  );

  int total = 0;
  int bad   = 0;

  typedef enum {M_STOP, M_RUN, M_CLEAR, M_LAP} mstate_t;
  mstate_t    m_st;
  int         m_left;
  logic [2:0] hist[$];   // button samples per clock edge, {lap, clear, run}

  function automatic logic [1:0] code_of(mstate_t s);
    case (s)
      M_STOP:  return 2'b00;
      M_RUN:   return 2'b01;
      M_CLEAR: return 2'b10;
      default: return 2'b11;
    endcase
  endfunction

  task automatic chk(string tag, logic [1:0] obs, logic [1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(string tag, int obs, int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(string tag);
    chk({tag, ".state"}, sw_if.o_state, code_of(m_st));
    chk({tag, ".run"},   {1'b0, sw_if.o_run},   {1'b0, (m_st == M_RUN) || (m_st == M_LAP)});
    chk({tag, ".clear"}, {1'b0, sw_if.o_clear}, {1'b0, m_st == M_CLEAR});
    chk({tag, ".lap"},   {1'b0, sw_if.o_lap},   {1'b0, m_st == M_LAP});
  endtask

  // A rise sampled two edges back decides the state taken at this edge.
  task automatic model_edge();
    logic [2:0] rise;
    rise = hist[hist.size()-3] & ~hist[hist.size()-4];
    case (m_st)
      M_STOP:  if (rise[0]) m_st = M_RUN;
               else if (rise[1]) begin m_st = M_CLEAR; m_left = CC - 1; end
      M_RUN:   if (rise[0]) m_st = M_STOP; else if (rise[2]) m_st = M_LAP;
      M_LAP:   if (rise[0]) m_st = M_STOP; else if (rise[2]) m_st = M_RUN;
      default: if (m_left == 0) m_st = M_STOP; else m_left--;
    endcase
    while (hist.size() > 8) void'(hist.pop_front());
  endtask

  task automatic tick(logic [2:0] b, string tag);
    sw_if.i_btn_run   = b[0];
    sw_if.i_btn_clear = b[1];
    sw_if.i_btn_lap   = b[2];
    @(posedge clk);
    hist.push_back(b);
    model_edge();
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic model_reset();
    m_st   = M_STOP;
    m_left = 0;
    hist   = {3'b000, 3'b000, 3'b000, 3'b000};
  endtask

  task automatic do_reset();
    sw_if.i_btn_run   = 1'b0;
    sw_if.i_btn_clear = 1'b0;
    sw_if.i_btn_lap   = 1'b0;
    rst = 1'b0;
    model_reset();
    repeat (5) @(negedge clk);
    check_outputs("reset");
    rst = 1'b1;
  endtask

  initial begin
    int n_clear;
    int n_trans;
    logic [1:0] prev_state;
    logic [2:0] rb;

    do_reset();
    repeat (20) tick(3'b000, "idle");

    // run toggle: exactly two clocks of latency
    tick(3'b001, "run_p1");
    tick(3'b000, "run_p1_lat1");
    chk("run_not_yet", {1'b0, sw_if.o_run}, 2'b00);
    tick(3'b000, "run_p1_lat2");
    chk("run_after_2", {1'b0, sw_if.o_run}, 2'b01);
    chk("run_state", sw_if.o_state, 2'b01);
    repeat (7) tick(3'b000, "run_hold");
    tick(3'b001, "run_p2");
    repeat (2) tick(3'b000, "run_p2_lat");
    chk("stop_state", sw_if.o_state, 2'b00);
    repeat (3) tick(3'b000, "gap");

    // clear pulse with a run pulse landing inside CLEAR
    n_clear = 0;
    tick(3'b010, "clr_p");
    for (int i = 0; i < 12; i++) begin
      tick((i == 3) ? 3'b001 : 3'b000, "clr_seq");
      if (sw_if.o_clear) n_clear++;
      chk("clr_norun", {1'b0, sw_if.o_run}, 2'b00);
    end
    chk_int("clear_width", n_clear, CC);
    chk("clr_end_state", sw_if.o_state, 2'b00);

    // lap sequence
    tick(3'b001, "lap_run");
    repeat (3) tick(3'b000, "lap_w");
    tick(3'b100, "lap_p1");
    repeat (3) tick(3'b000, "lap_w1");
    chk("lap_state", sw_if.o_state, 2'b11);
    tick(3'b100, "lap_p2");
    repeat (3) tick(3'b000, "lap_w2");
    chk("lap_release", sw_if.o_state, 2'b01);
    tick(3'b100, "lap_p3");
    repeat (3) tick(3'b000, "lap_w3");
    tick(3'b001, "lap_runstop");
    repeat (3) tick(3'b000, "lap_w4");
    chk("lap_stop", sw_if.o_state, 2'b00);

    // simultaneous run+lap in RUN -> STOP
    tick(3'b001, "sim_run");
    repeat (3) tick(3'b000, "sim_w");
    tick(3'b101, "sim_both");
    repeat (3) tick(3'b000, "sim_w2");
    chk("sim_stop", sw_if.o_state, 2'b00);

    // run held 50 cycles from STOP -> exactly one transition
    n_trans = 0;
    prev_state = sw_if.o_state;
    for (int i = 0; i < 50; i++) begin
      tick(3'b001, "held_run");
      if (sw_if.o_state != prev_state) n_trans++;
      prev_state = sw_if.o_state;
    end
    chk_int("held_transitions", n_trans, 1);
    tick(3'b000, "held_rel");
    tick(3'b001, "held_stop");
    repeat (3) tick(3'b000, "held_w");

    // async reset during the second CLEAR cycle
    tick(3'b010, "arst_clr");
    repeat (3) tick(3'b000, "arst_w");
    chk("arst_in_clear", sw_if.o_state, 2'b10);
    #2 rst = 1'b0;
    #1;
    chk("arst_clear_low", {1'b0, sw_if.o_clear}, 2'b00);
    chk("arst_state", sw_if.o_state, 2'b00);
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 10; i++) begin
      tick(3'b000, "arst_after");
      chk("arst_no_clear", {1'b0, sw_if.o_clear}, 2'b00);
    end

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      rb[0] = ($urandom_range(0, 5) == 0);
      rb[1] = ($urandom_range(0, 7) == 0);
      rb[2] = ($urandom_range(0, 5) == 0);
      tick(rb, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
